// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared constants, entry layout and FSM encoding for the fetch unit
package ifetch_pkg;

    localparam logic [3:0]  EXC_IADDR_MISALIGNED = 4'd0;
    localparam logic [3:0]  EXC_IACCESS_FAULT    = 4'd1;
    localparam logic [31:0] NOP_INSTR            = 32'h00000013;

    // {pc, instr, exc_en, exc_code, exc_val}
    localparam int ENTRY_W = 64 + 32 + 1 + 4 + 64;

    typedef enum logic [0:0] {
        ST_FETCH      = 1'b0,
        ST_FAULT_WAIT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc_en;
        logic [3:0]  exc_code;
        logic [63:0] exc_val;
    } fetch_entry_t;

    // Value shown on the decode side whenever no entry is available
    function automatic fetch_entry_t idle_entry();
        fetch_entry_t e;
        e.pc       = 64'h0;
        e.instr    = NOP_INSTR;
        e.exc_en   = 1'b0;
        e.exc_code = 4'h0;
        e.exc_val  = 64'h0;
        return e;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - fetched-instruction buffer with synchronous flush, push and pop
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     pop,
    output logic [ENTRY_W-1:0]       head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]      rd_q, rd_d;
    logic [AW-1:0]      wr_q, wr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               push_ok;
    logic               pop_ok;

    // Storage, pointers and occupancy; a flush with a push leaves exactly that one entry
    always_comb begin
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        pop_ok  = pop && (count_q != '0);
        push_ok = push && ((count_q < CW'(DEPTH)) || pop_ok);
        if (flush) begin
            rd_d = '0;
            if (push) begin
                mem_d[0] = push_data;
                wr_d     = AW'(1);
                count_d  = CW'(1);
            end else begin
                wr_d    = '0;
                count_d = '0;
            end
        end else begin
            if (push_ok) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_d = rd_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Buffer state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    assign head_data = mem_q[rd_q];
    assign count     = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch: pc sequencing, fault handling and redirect into a small buffer
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] pc_addr,
    input  logic [31:0] instruction,
    input  logic        imem_exc_en,
    input  logic [3:0]  imem_exc_code,
    input  logic [63:0] imem_exc_val,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    output logic        if_exc_en,
    output logic [3:0]  if_exc_code,
    output logic [63:0] if_exc_val
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_e   state_q, state_d;
    logic [63:0]    pc_q, pc_d;
    logic [CW-1:0]  fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    fetch_entry_t   head_entry;
    fetch_entry_t   push_entry;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_flush;
    logic           pop_req;
    logic           room;
    logic           fetch_push;
    logic           misaligned;

    assign pc_addr    = pc_q;
    assign if_valid   = (fifo_count != '0);
    assign pop_req    = if_valid && if_ready;
    assign misaligned = (redirect_pc[1:0] != 2'b00);
    assign room       = (fifo_count < DEPTH_C) || ((fifo_count == DEPTH_C) && pop_req);
    assign fetch_push = (state_q == ST_FETCH) && room;

    // FSM state and fetch pc registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state: redirect wins; a faulting fetch parks the unit until the next redirect
    always_comb begin
        state_d = state_q;
        if (redirect_en) begin
            state_d = misaligned ? ST_FAULT_WAIT : ST_FETCH;
        end else if (fetch_push && imem_exc_en) begin
            state_d = ST_FAULT_WAIT;
        end
    end

    // Datapath controls: what enters the buffer and where pc goes next
    always_comb begin
        fifo_flush = redirect_en;
        fifo_pop   = pop_req && !redirect_en;
        fifo_push  = 1'b0;
        pc_d       = pc_q;
        push_entry.pc       = pc_q;
        push_entry.instr    = imem_exc_en ? NOP_INSTR : instruction;
        push_entry.exc_en   = imem_exc_en;
        push_entry.exc_code = imem_exc_en ? imem_exc_code : 4'h0;
        push_entry.exc_val  = imem_exc_en ? imem_exc_val : 64'h0;
        if (redirect_en) begin
            pc_d = redirect_pc;
            if (misaligned) begin
                fifo_push           = 1'b1;
                push_entry.pc       = redirect_pc;
                push_entry.instr    = NOP_INSTR;
                push_entry.exc_en   = 1'b1;
                push_entry.exc_code = EXC_IADDR_MISALIGNED;
                push_entry.exc_val  = redirect_pc;
            end
        end else if (fetch_push) begin
            fifo_push = 1'b1;
            if (!imem_exc_en) begin
                pc_d = pc_q + 64'd4;
            end
        end
    end

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    // Decode-facing view of the head entry, idle pattern when empty
    always_comb begin
        head_entry  = if_valid ? fetch_entry_t'(fifo_head) : idle_entry();
        if_pc       = head_entry.pc;
        if_instr    = head_entry.instr;
        if_exc_en   = head_entry.exc_en;
        if_exc_code = head_entry.exc_code;
        if_exc_val  = head_entry.exc_val;
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit
module tb_ifetch_unit;
    import ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] pc_addr;
    logic [31:0] instruction;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;
    logic        redirect_en = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        if_exc_en;
    logic [3:0]  if_exc_code;
    logic [63:0] if_exc_val;

    logic        fault_on   = 1'b0;
    logic [63:0] fault_addr = 64'h2000;

    int checks = 0;
    int errors = 0;
    int drain_gaps;
    fetch_entry_t sb_q[$];

    always #5 clk = ~clk;

    // Instruction memory model: data derived from the address, optional access fault at one address
    always_comb begin
        instruction   = pc_addr[31:0] ^ 32'hC0DE_0000;
        imem_exc_en   = fault_on && (pc_addr == fault_addr);
        imem_exc_code = EXC_IACCESS_FAULT;
        imem_exc_val  = pc_addr;
    end

    ifetch_unit #(
        .RESET_PC   (64'h0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_addr       (pc_addr),
        .instruction   (instruction),
        .imem_exc_en   (imem_exc_en),
        .imem_exc_code (imem_exc_code),
        .imem_exc_val  (imem_exc_val),
        .redirect_en   (redirect_en),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_exc_en     (if_exc_en),
        .if_exc_code   (if_exc_code),
        .if_exc_val    (if_exc_val)
    );

    function automatic fetch_entry_t ok_entry(input logic [63:0] pc);
        fetch_entry_t e;
        e.pc       = pc;
        e.instr    = pc[31:0] ^ 32'hC0DE_0000;
        e.exc_en   = 1'b0;
        e.exc_code = 4'h0;
        e.exc_val  = 64'h0;
        return e;
    endfunction

    function automatic fetch_entry_t exc_entry(input logic [63:0] pc, input logic [3:0] code);
        fetch_entry_t e;
        e.pc       = pc;
        e.instr    = 32'h00000013;
        e.exc_en   = 1'b1;
        e.exc_code = code;
        e.exc_val  = pc;
        return e;
    endfunction

    // Called at a negedge; compares every visible head against the scoreboard until it is empty
    task automatic drain(input int budget);
        fetch_entry_t exp_e;
        fetch_entry_t got_e;
        int  cyc = 0;
        bit  seen = 0;
        drain_gaps = 0;
        while (sb_q.size() != 0 && cyc < budget) begin
            if (if_valid) begin
                seen  = 1;
                exp_e = sb_q.pop_front();
                got_e.pc = if_pc; got_e.instr = if_instr; got_e.exc_en = if_exc_en;
                got_e.exc_code = if_exc_code; got_e.exc_val = if_exc_val;
                checks++;
                if (got_e !== exp_e) begin
                    errors++;
                    $display("FAIL drain_entry got pc=%h instr=%h exc=%b code=%h val=%h expected pc=%h instr=%h exc=%b code=%h val=%h",
                             got_e.pc, got_e.instr, got_e.exc_en, got_e.exc_code, got_e.exc_val,
                             exp_e.pc, exp_e.instr, exp_e.exc_en, exp_e.exc_code, exp_e.exc_val);
                end
            end else if (seen) begin
                drain_gaps++;
            end
            if (sb_q.size() != 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d entries left expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        redirect_en = 1'b0;
        fault_on    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_redirect(input logic [63:0] target);
        redirect_en = 1'b1;
        redirect_pc = target;
        @(negedge clk);
        redirect_en = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({if_valid, if_instr, if_pc, if_exc_en, if_exc_code, if_exc_val} !== {1'b0, 32'h00000013, 64'h0, 1'b0, 4'h0, 64'h0}) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b instr=%h pc=%h exc=%b code=%h val=%h expected 0/00000013/0/0/0/0",
                     if_valid, if_instr, if_pc, if_exc_en, if_exc_code, if_exc_val);
        end
        checks++;
        if (pc_addr !== 64'h0) begin
            errors++;
            $display("FAIL reset_pc_addr got %h expected %h", pc_addr, 64'h0);
        end
    endtask

    task automatic test_sequential();
        if_ready = 1'b1;
        do_reset();
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_first_cycle_valid got %b expected 0", if_valid);
        end
        for (int i = 0; i < 10; i++) sb_q.push_back(ok_entry(64'(4 * i)));
        @(negedge clk);
        drain(20);
        checks++;
        if (drain_gaps != 0) begin
            errors++;
            $display("FAIL seq_bubbles got %0d expected 0", drain_gaps);
        end
    endtask

    task automatic test_backpressure();
        if_ready = 1'b0;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                checks++;
                if (pc_addr !== 64'h8) begin
                    errors++;
                    $display("FAIL stall_pc_addr got %h expected %h", pc_addr, 64'h8);
                end
            end
        end
        checks++;
        if ({if_valid, if_pc} !== {1'b1, 64'h0}) begin
            errors++;
            $display("FAIL stall_head got valid=%b pc=%h expected 1/0", if_valid, if_pc);
        end
        if_ready = 1'b1;
        for (int i = 0; i < 4; i++) sb_q.push_back(ok_entry(64'(4 * i)));
        drain(10);
    endtask

    task automatic test_fault();
        if_ready   = 1'b1;
        fault_addr = 64'h2000;
        do_reset();
        fault_on = 1'b1;
        pulse_redirect(64'h1FF0);
        for (int i = 0; i < 4; i++) sb_q.push_back(ok_entry(64'h1FF0 + 64'(4 * i)));
        sb_q.push_back(exc_entry(64'h2000, EXC_IACCESS_FAULT));
        drain(20);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            fault_on = i[0];
            checks++;
            if ({if_valid, pc_addr} !== {1'b0, 64'h2000}) begin
                errors++;
                $display("FAIL fault_wait_idle got valid=%b pc_addr=%h expected 0/2000", if_valid, pc_addr);
            end
        end
        fault_on = 1'b0;
    endtask

    task automatic test_redirect_full();
        if_ready = 1'b0;
        do_reset();
        repeat (4) @(negedge clk);
        checks++;
        if ({if_valid, if_pc, pc_addr} !== {1'b1, 64'h0, 64'h8}) begin
            errors++;
            $display("FAIL full_before_redirect got valid=%b pc=%h pc_addr=%h expected 1/0/8", if_valid, if_pc, pc_addr);
        end
        pulse_redirect(64'h100);
        checks++;
        if ({if_valid, pc_addr} !== {1'b0, 64'h100}) begin
            errors++;
            $display("FAIL redirect_flush got valid=%b pc_addr=%h expected 0/100", if_valid, pc_addr);
        end
        if_ready = 1'b1;
        sb_q.push_back(ok_entry(64'h100));
        sb_q.push_back(ok_entry(64'h104));
        drain(10);
    endtask

    task automatic test_misaligned();
        if_ready = 1'b0;
        do_reset();
        pulse_redirect(64'h102);
        repeat (3) @(negedge clk);
        checks++;
        if ({if_valid, pc_addr} !== {1'b1, 64'h102}) begin
            errors++;
            $display("FAIL misaligned_hold got valid=%b pc_addr=%h expected 1/102", if_valid, pc_addr);
        end
        if_ready = 1'b1;
        sb_q.push_back(exc_entry(64'h102, EXC_IADDR_MISALIGNED));
        drain(5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (if_valid !== 1'b0) begin
                errors++;
                $display("FAIL misaligned_single got valid=%b expected 0", if_valid);
            end
        end
        pulse_redirect(64'h0);
        for (int i = 0; i < 3; i++) sb_q.push_back(ok_entry(64'(4 * i)));
        drain(10);
    endtask

    task automatic test_reset_midstream();
        for (int sc = 0; sc < 2; sc++) begin
            if_ready = 1'b0;
            do_reset();
            if (sc == 1) pulse_redirect(64'h6);
            repeat (3) @(negedge clk);
            #2 rst = 1'b1;
            #1;
            checks++;
            if ({if_valid, pc_addr, if_pc, if_instr} !== {1'b0, 64'h0, 64'h0, 32'h00000013}) begin
                errors++;
                $display("FAIL midstream_reset got valid=%b pc_addr=%h pc=%h instr=%h expected 0/0/0/00000013",
                         if_valid, pc_addr, if_pc, if_instr);
            end
            @(negedge clk);
            rst      = 1'b0;
            if_ready = 1'b1;
            sb_q.push_back(ok_entry(64'h0));
            sb_q.push_back(ok_entry(64'h4));
            drain(10);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_fault();
        test_redirect_full();
        test_misaligned();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
